// File: rtl/div_sqrt_iter_engine.sv
// Radix-2 non-restoring divide / square-root iteration engine, C_UNROLL steps per cycle.
// Optional sticky output (corrected remainder != 0) built only when DIV_SQRT_STICKY_EN is defined.
module div_sqrt_iter_engine #(
    parameter int unsigned C_MANT   = 52,
    parameter int unsigned C_UNROLL = 1
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Start_SI,
    input  logic              Div_enable_SI,
    input  logic              Kill_SI,
    input  logic [C_MANT+1:0] A_DI,
    input  logic [C_MANT:0]   B_DI,
    output logic              Ready_SO,
    output logic              Done_SO,
    output logic [C_MANT+1:0] Quot_DO,
    output logic              Sticky_SO
);

    localparam int unsigned C_ITER     = C_MANT + 2;
    localparam int unsigned N_CYC      = (C_ITER + C_UNROLL - 1) / C_UNROLL;
    localparam int unsigned LAST_STEPS = C_ITER - (N_CYC - 1) * C_UNROLL;
    // Two bits of headroom over the divide remainder so the sqrt 4R term never overflows.
    localparam int unsigned RW         = C_MANT + 6;
    localparam int unsigned QW         = C_ITER;
    localparam int unsigned RADW       = C_ITER + (C_MANT % 2);
    localparam int unsigned CW         = $clog2(N_CYC + 1);

    typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [RW-1:0]     r_q, r_c;
    logic [QW-1:0]     q_q, q_c;
    logic [RADW-1:0]   rad_q, rad_c;
    logic [C_MANT:0]   b_q;
    logic              div_q, first_q;
    logic [QW-1:0]     quot_q;
    logic              ready_q, done_q;
    logic              load, step_en, finish;

    // State register
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ITER);
            done_q  <= (state_d == FINAL);
        end
    end

    // Next state; kill wins over everything, FINAL accepts a back-to-back start
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step_en = 1'b0;
        finish  = 1'b0;
        if (Kill_SI) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, FINAL: begin
                    if (Start_SI) begin
                        state_d = ITER;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ITER: begin
                    step_en = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = FINAL;
                        finish  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Unrolled add/sub chain; surplus steps in the last cycle hold R, Q and the radicand
    always_comb begin
        r_c   = r_q;
        q_c   = q_q;
        rad_c = rad_q;
        for (int unsigned j = 0; j < C_UNROLL; j++) begin
            if ((cnt_q != '0) || (j < LAST_STEPS)) begin
                if (div_q) begin
                    if (first_q && (j == 0))
                        r_c = r_c - RW'(b_q);
                    else if (!r_c[RW-1])
                        r_c = {r_c[RW-2:0], 1'b0} - RW'(b_q);
                    else
                        r_c = {r_c[RW-2:0], 1'b0} + RW'(b_q);
                end else begin
                    if (!r_c[RW-1])
                        r_c = {r_c[RW-3:0], 2'b00} + RW'(rad_c[RADW-1 -: 2])
                              - RW'({q_c, 2'b01});
                    else
                        r_c = {r_c[RW-3:0], 2'b00} + RW'(rad_c[RADW-1 -: 2])
                              + RW'({q_c, 2'b11});
                    rad_c = {rad_c[RADW-3:0], 2'b00};
                end
                q_c = {q_c[QW-2:0], ~r_c[RW-1]};
            end
        end
    end

    // Operand, iteration and result registers
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            rad_q   <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            first_q <= 1'b0;
            quot_q  <= '0;
        end else begin
            if (load) begin
                cnt_q   <= CW'(N_CYC - 1);
                r_q     <= Div_enable_SI ? RW'(A_DI) : '0;
                q_q     <= '0;
                rad_q   <= RADW'(A_DI) << (RADW - C_ITER);
                b_q     <= B_DI;
                div_q   <= Div_enable_SI;
                first_q <= 1'b1;
            end else if (step_en) begin
                r_q     <= r_c;
                q_q     <= q_c;
                rad_q   <= rad_c;
                first_q <= 1'b0;
                if (cnt_q != '0)
                    cnt_q <= cnt_q - CW'(1);
            end
            if (finish)
                quot_q <= q_c;
        end
    end

`ifdef DIV_SQRT_STICKY_EN
    logic [RW-1:0] rem_corr;
    logic          sticky_q;

    // Add back B (divide) or 2Q+1 (sqrt) to a negative final remainder
    always_comb begin
        rem_corr = r_c;
        if (r_c[RW-1])
            rem_corr = div_q ? (r_c + RW'(b_q)) : (r_c + RW'({q_c, 1'b1}));
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI)
            sticky_q <= 1'b0;
        else if (finish)
            sticky_q <= |rem_corr;
    end

    assign Sticky_SO = sticky_q;
`else
    assign Sticky_SO = 1'b0;
`endif

    assign Ready_SO = ready_q;
    assign Done_SO  = done_q;
    assign Quot_DO  = quot_q;

endmodule

// File: tb/tb_div_sqrt_iter_engine.sv
// Bench for div_sqrt_iter_engine: three unroll factors (1,2,3) at C_MANT=8 share one stimulus
// stream and are checked every cycle against a latency/arithmetic reference model.
module tb_div_sqrt_iter_engine;

    localparam int M = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       div_en = 1'b0;
    logic       kill = 1'b0;
    logic [9:0] a_in = 10'h100;
    logic [8:0] b_in = 9'h100;

    logic       ready [3];
    logic       done  [3];
    logic [9:0] quot  [3];
    logic       sticky[3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_sqrt_iter_engine #(.C_MANT(M), .C_UNROLL(1)) u_dut1 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Div_enable_SI(div_en), .Kill_SI(kill),
        .A_DI(a_in), .B_DI(b_in), .Ready_SO(ready[0]), .Done_SO(done[0]), .Quot_DO(quot[0]),
        .Sticky_SO(sticky[0]));
    div_sqrt_iter_engine #(.C_MANT(M), .C_UNROLL(2)) u_dut2 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Div_enable_SI(div_en), .Kill_SI(kill),
        .A_DI(a_in), .B_DI(b_in), .Ready_SO(ready[1]), .Done_SO(done[1]), .Quot_DO(quot[1]),
        .Sticky_SO(sticky[1]));
    div_sqrt_iter_engine #(.C_MANT(M), .C_UNROLL(3)) u_dut3 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Div_enable_SI(div_en), .Kill_SI(kill),
        .A_DI(a_in), .B_DI(b_in), .Ready_SO(ready[2]), .Done_SO(done[2]), .Quot_DO(quot[2]),
        .Sticky_SO(sticky[2]));

    // Iteration cycles per instance (ceil(10/U)); start-to-done latency is one more
    int ncyc   [3] = '{10, 5, 4};
    int lat_lit[3] = '{11, 6, 5};

    function automatic logic [9:0] ref_quot(input logic dv, input logic [9:0] a, input logic [8:0] b);
        longint x, q, t;
        if (dv) return 10'((longint'(a) << (M + 1)) / longint'(b));
        x = longint'(a) << (M + 2);
        q = 0;
        for (int i = 10; i >= 0; i--) begin
            t = q + (longint'(1) << i);
            if (t * t <= x) q = t;
        end
        return 10'(q);
    endfunction

    function automatic logic ref_sticky(input logic dv, input logic [9:0] a, input logic [8:0] b);
`ifdef DIV_SQRT_STICKY_EN
        longint qq;
        qq = longint'(ref_quot(dv, a, b));
        if (dv) return ((longint'(a) << (M + 1)) % longint'(b)) != 0;
        return ((longint'(a) << (M + 2)) - qq * qq) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h want=%h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Reference model: busy/done timing plus arithmetic results
    bit         m_busy  [3] = '{0, 0, 0};
    int         m_cnt   [3] = '{0, 0, 0};
    logic       m_done  [3] = '{0, 0, 0};
    logic [9:0] m_quot  [3] = '{0, 0, 0};
    logic       m_sticky[3] = '{0, 0, 0};
    logic [9:0] p_quot  [3] = '{0, 0, 0};
    logic       p_sticky[3] = '{0, 0, 0};
    bit         acc_m;

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_busy[k] = 0; m_cnt[k] = 0; m_done[k] = 0; m_quot[k] = '0; m_sticky[k] = 0;
            end else begin
                acc_m = start && !m_busy[k] && !kill;
                m_done[k] = 0;
                if (kill) begin
                    m_busy[k] = 0;
                end else begin
                    if (m_busy[k]) begin
                        m_cnt[k]--;
                        if (m_cnt[k] == 0) begin
                            m_busy[k] = 0; m_done[k] = 1;
                            m_quot[k] = p_quot[k]; m_sticky[k] = p_sticky[k];
                        end
                    end
                    if (acc_m) begin
                        p_quot[k]   = ref_quot(div_en, a_in, b_in);
                        p_sticky[k] = ref_sticky(div_en, a_in, b_in);
                        m_busy[k]   = 1;
                        m_cnt[k]    = ncyc[k];
                    end
                end
            end
        end
    end

    // Per-cycle compare on the falling edge
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                chk("rst_ready", k, 16'(ready[k]), 16'(1));
                chk("rst_done", k, 16'(done[k]), 16'(0));
                chk("rst_quot", k, 16'(quot[k]), 16'(0));
                chk("rst_sticky", k, 16'(sticky[k]), 16'(0));
            end else begin
                chk("ready", k, 16'(ready[k]), 16'(!m_busy[k]));
                chk("done", k, 16'(done[k]), 16'(m_done[k]));
                chk("quot", k, 16'(quot[k]), 16'(m_quot[k]));
                chk("sticky", k, 16'(sticky[k]), 16'(m_sticky[k]));
            end
        end
    end

    task automatic idle_cycles(input int n);
        start = 0; kill = 0;
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    // One op on all three instances; literal latency/result/sticky checks
    task automatic run_op(input logic dv, input logic [9:0] a, input logic [8:0] b,
                          input logic [9:0] q_lit, input logic s_lit);
        int         lat[3];
        logic [9:0] qs[3];
        logic       ss[3];
        logic       s_exp;
`ifdef DIV_SQRT_STICKY_EN
        s_exp = s_lit;
`else
        s_exp = 1'b0;
`endif
        for (int k = 0; k < 3; k++) begin lat[k] = -1; qs[k] = '0; ss[k] = 1'b0; end
        div_en = dv; a_in = a; b_in = b; start = 1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = 0;
            for (int k = 0; k < 3; k++)
                if (lat[k] < 0 && done[k]) begin lat[k] = c; qs[k] = quot[k]; ss[k] = sticky[k]; end
        end
        for (int k = 0; k < 3; k++) begin
            chk("lit_latency", k, 16'(lat[k]), 16'(lat_lit[k]));
            chk("lit_quot", k, 16'(qs[k]), 16'(q_lit));
            chk("lit_sticky", k, 16'(ss[k]), 16'(s_exp));
        end
    endtask

    int         lat2;
    logic [9:0] q2;

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", k, 16'(ready[k]), 16'(1));
            chk("reset_quot", k, 16'(quot[k]), 16'(0));
        end
        #2 rst_n = 1;
        idle_cycles(2);

        run_op(1'b1, 10'h180, 9'h100, 10'h300, 1'b0);
        run_op(1'b1, 10'h100, 9'h180, 10'h155, 1'b1);
        run_op(1'b0, 10'h100, 9'h000, 10'h200, 1'b0);
        run_op(1'b0, 10'h200, 9'h1FF, 10'h2D4, 1'b1);

        // Kill together with start in cycle 2: nothing completes, results held
        div_en = 1; a_in = 10'h180; b_in = 9'h100; start = 1;
        @(posedge clk); #1; start = 0;
        @(posedge clk); #1; start = 1; kill = 1;
        @(posedge clk); #1; start = 0; kill = 0;
        for (int k = 0; k < 3; k++) begin
            chk("kill_ready", k, 16'(ready[k]), 16'(1));
            chk("kill_quot", k, 16'(quot[k]), 16'(10'h2D4));
        end
        idle_cycles(15);
        run_op(1'b1, 10'h180, 9'h100, 10'h300, 1'b0);

        // Back-to-back: second start in the U=2 instance's done cycle
        div_en = 1; a_in = 10'h180; b_in = 9'h100; start = 1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1; start = 0;
            if (done[1]) break;
        end
        a_in = 10'h100; b_in = 9'h180; start = 1;
        lat2 = -1; q2 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1; start = 0;
            if (done[1]) begin lat2 = c; q2 = quot[1]; break; end
        end
        chk("b2b_latency", 1, 16'(lat2), 16'(6));
        chk("b2b_quot", 1, 16'(q2), 16'(10'h155));
        idle_cycles(15);

        // Randomised traffic including ignored starts while busy and occasional kills
        for (int i = 0; i < 3000; i++) begin
            div_en = 1'($urandom_range(0, 1));
            a_in   = div_en ? 10'($urandom_range(256, 511)) : 10'($urandom_range(256, 1023));
            b_in   = 9'($urandom_range(256, 511));
            start  = ($urandom_range(0, 3) == 0);
            kill   = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        idle_cycles(15);

        // Asynchronous reset mid-operation
        div_en = 0; a_in = 10'h200; start = 1;
        @(posedge clk); #1; start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_ready", k, 16'(ready[k]), 16'(1));
            chk("async_done", k, 16'(done[k]), 16'(0));
            chk("async_quot", k, 16'(quot[k]), 16'(0));
            chk("async_sticky", k, 16'(sticky[k]), 16'(0));
        end
        @(posedge clk); @(posedge clk); #3 rst_n = 1;
        idle_cycles(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
